icache_responder: RTL and testbench

Instruction-side memory responder. It serves the frontend's word-fetch port (`imem_addr`, `imem_rmask`, `imem_rdata`, `imem_resp`) from a small 2-way set-associative cache. On a miss it refills a 32-byte line from a burst memory port delivering 64-bit beats. It sits between the frontend and the memory arbiter, and is the responder side of the fetch protocol the frontend initiates.

---
 rtl/icache_responder_pkg.sv | 16 +
 rtl/icache_responder_array.sv | 50 +++++
 rtl/icache_responder.sv | 165 ++++++++++++++++
 tb/tb_icache_responder.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_responder_pkg.sv
// Shared geometry and FSM state type for the instruction-side cache responder.
package icache_types;
    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned INDEX_W  = 4;
    localparam int unsigned TAG_W    = 32 - OFFSET_W - INDEX_W;
    localparam int unsigned BEAT_W   = 64;
    localparam int unsigned BEATS    = 4;
    localparam int unsigned WORD_W   = 32;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRefill,
        StFill
    } icache_state_t;
endpackage

// File: rtl/icache_responder_array.sv
// One cache way: flop-based tag/valid/line storage with a combinational read port
// and a synchronous whole-line write port.
module icache_array #(
    parameter int unsigned NumSets = 16,
    parameter int unsigned IndexW  = 4,
    parameter int unsigned TagW    = 23,
    parameter int unsigned LineW   = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IndexW-1:0] rd_idx_i,
    output logic              rd_valid_o,
    output logic [TagW-1:0]   rd_tag_o,
    output logic [LineW-1:0]  rd_line_o,
    input  logic              wr_en_i,
    input  logic [IndexW-1:0] wr_idx_i,
    input  logic [TagW-1:0]   wr_tag_i,
    input  logic [LineW-1:0]  wr_line_i
);
    logic [NumSets-1:0] valid_q, valid_d;
    logic [TagW-1:0]    tag_q  [NumSets];
    logic [LineW-1:0]   line_q [NumSets];

    always_comb begin
        valid_d = valid_q;
        if (wr_en_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data need no reset; valid gates every read.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            line_q[wr_idx_i] <= wr_line_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_line_o  = line_q[rd_idx_i];
endmodule

// File: rtl/icache_responder.sv
// 2-way set-associative instruction fetch responder with burst line refill.
// Responses always belong to the address sampled in the previous IDLE cycle.
module icache_responder
    import icache_types::*;
#(
    parameter int unsigned NUM_SETS   = 16,
    parameter int unsigned NUM_WAYS   = 2,
    parameter int unsigned LINE_BYTES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    input  logic [63:0] mem_rdata,
    input  logic        mem_rvalid
);
    localparam int unsigned OffW     = $clog2(LINE_BYTES);
    localparam int unsigned IndexW   = $clog2(NUM_SETS);
    localparam int unsigned TagW     = 32 - OffW - IndexW;
    localparam int unsigned LineW    = LINE_BYTES * 8;
    localparam int unsigned Beats    = LineW / BEAT_W;
    localparam int unsigned BeatCntW = $clog2(Beats);
    localparam int unsigned Words    = LineW / WORD_W;
    localparam int unsigned LruW     = NUM_SETS * (NUM_WAYS - 1);

    icache_state_t state_q, state_d;
    logic [31:2]                  addr_q, addr_d;
    logic                         valid_q, valid_d;
    logic [BeatCntW-1:0]          beat_q, beat_d;
    logic [Beats-1:0][BEAT_W-1:0] buf_q, buf_d;
    logic                         victim_q, victim_d;
    logic [LruW-1:0]              lru_q, lru_d;

    logic [IndexW-1:0]            idx;
    logic [TagW-1:0]              tag;
    logic [OffW-3:0]              woff;
    logic                         v0, v1, hit0, hit1, hit, fill_en;
    logic [TagW-1:0]              tag0, tag1;
    logic [LineW-1:0]             line0, line1;
    logic [Words-1:0][WORD_W-1:0] hit_words;
    logic                         unused_addr;

    assign unused_addr = ^imem_addr[1:0];

    assign idx  = addr_q[OffW+IndexW-1:OffW];
    assign tag  = addr_q[31:OffW+IndexW];
    assign woff = addr_q[OffW-1:2];

    icache_array #(
        .NumSets (NUM_SETS),
        .IndexW  (IndexW),
        .TagW    (TagW),
        .LineW   (LineW)
    ) u_way0 (
        .clk_i      (clk),
        .rst_i      (rst),
        .rd_idx_i   (idx),
        .rd_valid_o (v0),
        .rd_tag_o   (tag0),
        .rd_line_o  (line0),
        .wr_en_i    (fill_en && !victim_q),
        .wr_idx_i   (idx),
        .wr_tag_i   (tag),
        .wr_line_i  (buf_q)
    );

    icache_array #(
        .NumSets (NUM_SETS),
        .IndexW  (IndexW),
        .TagW    (TagW),
        .LineW   (LineW)
    ) u_way1 (
        .clk_i      (clk),
        .rst_i      (rst),
        .rd_idx_i   (idx),
        .rd_valid_o (v1),
        .rd_tag_o   (tag1),
        .rd_line_o  (line1),
        .wr_en_i    (fill_en && victim_q),
        .wr_idx_i   (idx),
        .wr_tag_i   (tag),
        .wr_line_i  (buf_q)
    );

    assign hit0      = v0 && (tag0 == tag);
    assign hit1      = v1 && (tag1 == tag);
    assign hit       = hit0 || hit1;
    assign hit_words = hit0 ? line0 : line1;

    assign imem_resp  = (state_q == StIdle) && valid_q && hit;
    assign imem_rdata = imem_resp ? hit_words[woff] : '0;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        beat_d   = beat_q;
        buf_d    = buf_q;
        victim_d = victim_q;
        lru_d    = lru_q;
        mem_read = 1'b0;
        mem_addr = '0;
        fill_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // The missing address is held; anything else resamples the port.
                if (valid_q && !hit) begin
                    state_d = StReq;
                end else begin
                    addr_d  = imem_addr[31:2];
                    valid_d = |imem_rmask;
                end
                if (valid_q && hit) begin
                    lru_d[idx] = hit0;
                end
            end
            StReq: begin
                mem_read = 1'b1;
                mem_addr = {addr_q[31:OffW], {OffW{1'b0}}};
                victim_d = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru_q[idx]);
                state_d  = StRefill;
            end
            StRefill: begin
                if (mem_rvalid) begin
                    buf_d[beat_q] = mem_rdata;
                    beat_d        = beat_q + 1'b1;
                    if (beat_q == BeatCntW'(Beats - 1)) begin
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                fill_en    = 1'b1;
                lru_d[idx] = ~victim_q;
                valid_d    = 1'b0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            beat_q   <= '0;
            buf_q    <= '0;
            victim_q <= 1'b0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            beat_q   <= beat_d;
            buf_q    <= buf_d;
            victim_q <= victim_d;
            lru_q    <= lru_d;
        end
    end
endmodule

// File: tb/tb_icache_responder.sv
// Directed self-checking bench for icache_responder: miss/refill, hits, LRU, redirect, reset.
module tb_icache_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic [63:0] mem_rdata;
    logic        mem_rvalid;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] A = 32'h1000_0000;
    localparam logic [31:0] B = 32'h2000_0000;
    localparam logic [31:0] C = 32'h3000_0000;
    localparam logic [31:0] D = 32'h1000_0040;

    always #5 clk = ~clk;

    icache_responder dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    // Memory contents: line 0x1000_0000 is a fixed table, other words are address-derived.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [31:0] base;
        base = {a[31:5], 5'b0};
        if (base == 32'h1000_0000) begin
            case (a[4:2])
                3'd0:    return 32'h3333_4444;
                3'd1:    return 32'h1111_2222;
                3'd2:    return 32'h7777_8888;
                3'd3:    return 32'h5555_6666;
                3'd4:    return 32'hBBBB_CCCC;
                3'd5:    return 32'h9999_AAAA;
                3'd6:    return 32'hFFFF_0000;
                default: return 32'hDDDD_EEEE;
            endcase
        end
        return {a[31:2], 2'b00} ^ 32'hDEAD_0000;
    endfunction

    function automatic logic [63:0] beat_of(input logic [31:0] base, input int k);
        return {word_of(base + 32'(8 * k + 4)), word_of(base + 32'(8 * k))};
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst        = 1'b1;
        imem_rmask = 4'h0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic wait_mem_read(output bit found, output logic [31:0] addr);
        found = 1'b0;
        addr  = 'x;
        for (int i = 0; i < 20; i++) begin
            if (mem_read) begin
                found = 1'b1;
                addr  = mem_addr;
                break;
            end
            tick;
        end
    endtask

    // Returns at the FILL-cycle negedge.
    task automatic supply_beats(input logic [31:0] base, input int gap, input int redir_k,
                                input logic [31:0] redir_addr);
        for (int k = 0; k < 4; k++) begin
            tick;
            if (k == redir_k) imem_addr = redir_addr;
            mem_rvalid = 1'b1;
            mem_rdata  = beat_of(base, k);
            if (k < 3) begin
                for (int g = 0; g < gap; g++) begin
                    tick;
                    mem_rvalid = 1'b0;
                end
            end
        end
        tick;
        mem_rvalid = 1'b0;
    endtask

    task automatic fill_line(input logic [31:0] addr, input int gap, output bit found,
                             output logic [31:0] maddr);
        imem_addr  = addr;
        imem_rmask = 4'hF;
        tick;
        wait_mem_read(found, maddr);
        if (found) supply_beats({addr[31:5], 5'b0}, gap, -1, 32'h0);
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        imem_addr  = '0;
        imem_rmask = 4'h0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        tick;
        tick;
        checks++;
        if (imem_resp !== 1'b0) begin
            errors++; $display("FAIL reset_resp: got %b expected 0", imem_resp);
        end
        checks++;
        if (imem_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0", imem_rdata);
        end
        checks++;
        if (mem_read !== 1'b0 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_mem: got read=%b addr=%h expected 0/0", mem_read, mem_addr);
        end
        rst = 1'b0;
        tick;
        checks++;
        if (imem_resp !== 1'b0) begin
            errors++; $display("FAIL post_reset_resp: got %b expected 0", imem_resp);
        end
    endtask

    task automatic test_cold_miss;
        bit found;
        logic [31:0] ma;
        imem_addr  = 32'h1000_0004;
        imem_rmask = 4'hF;
        tick;
        checks++;
        if (imem_resp !== 1'b0 || mem_read !== 1'b0) begin
            errors++; $display("FAIL cold_miss_cycle: got resp=%b read=%b expected 0/0", imem_resp, mem_read);
        end
        wait_mem_read(found, ma);
        checks++;
        if (!found || ma !== A) begin
            errors++; $display("FAIL cold_mem_read: got found=%b addr=%h expected 1/%h", found, ma, A);
        end
        tick;
        checks++;
        if (mem_read !== 1'b0) begin
            errors++; $display("FAIL cold_read_pulse: got %b expected 0", mem_read);
        end
        supply_beats(A, 0, -1, 32'h0);
        checks++;
        if (imem_resp !== 1'b0) begin
            errors++; $display("FAIL cold_fill_resp: got %b expected 0", imem_resp);
        end
        tick;
        checks++;
        if (imem_resp !== 1'b0) begin
            errors++; $display("FAIL cold_resample_resp: got %b expected 0", imem_resp);
        end
        tick;
        checks++;
        if (imem_resp !== 1'b1 || imem_rdata !== 32'h1111_2222) begin
            errors++;
            $display("FAIL cold_resp: got resp=%b data=%h expected 1/11112222", imem_resp, imem_rdata);
        end
    endtask

    task automatic test_streaming;
        logic [31:0] a;
        for (int i = 0; i < 8; i++) begin
            a = A + 32'(4 * i);
            imem_addr = a;
            tick;
            checks++;
            if (imem_resp !== 1'b1 || imem_rdata !== word_of(a) || mem_read !== 1'b0) begin
                errors++;
                $display("FAIL stream_%0d: got resp=%b data=%h read=%b expected 1/%h/0",
                         i, imem_resp, imem_rdata, mem_read, word_of(a));
            end
        end
        imem_rmask = 4'h0;
        tick;
    endtask

    task automatic test_conflict_lru;
        bit found;
        logic [31:0] ma;
        do_reset;
        fill_line(A, 0, found, ma);
        tick;
        tick;
        checks++;
        if (!found || ma !== A || imem_resp !== 1'b1 || imem_rdata !== word_of(A)) begin
            errors++; $display("FAIL lru_fill_a: got addr=%h resp=%b data=%h expected %h/1/%h",
                               ma, imem_resp, imem_rdata, A, word_of(A));
        end
        fill_line(B, 1, found, ma);
        tick;
        tick;
        checks++;
        if (!found || ma !== B || imem_resp !== 1'b1 || imem_rdata !== word_of(B)) begin
            errors++; $display("FAIL lru_fill_b: got addr=%h resp=%b data=%h expected %h/1/%h",
                               ma, imem_resp, imem_rdata, B, word_of(B));
        end
        imem_addr = A;
        tick;
        checks++;
        if (imem_resp !== 1'b1 || imem_rdata !== word_of(A)) begin
            errors++; $display("FAIL lru_hit_a: got resp=%b data=%h expected 1/%h",
                               imem_resp, imem_rdata, word_of(A));
        end
        fill_line(C, 0, found, ma);
        tick;
        tick;
        checks++;
        if (!found || ma !== C || imem_resp !== 1'b1 || imem_rdata !== word_of(C)) begin
            errors++; $display("FAIL lru_fill_c: got addr=%h resp=%b data=%h expected %h/1/%h",
                               ma, imem_resp, imem_rdata, C, word_of(C));
        end
        imem_addr = A;
        tick;
        checks++;
        if (imem_resp !== 1'b1 || imem_rdata !== word_of(A)) begin
            errors++; $display("FAIL lru_a_kept: got resp=%b data=%h expected 1/%h",
                               imem_resp, imem_rdata, word_of(A));
        end
        imem_addr = B;
        tick;
        checks++;
        if (imem_resp !== 1'b0) begin
            errors++; $display("FAIL lru_b_evicted: got resp=%b expected 0", imem_resp);
        end
        tick;
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== B) begin
            errors++; $display("FAIL lru_b_refetch: got read=%b addr=%h expected 1/%h",
                               mem_read, mem_addr, B);
        end
        imem_rmask = 4'h0;
    endtask

    task automatic test_redirect;
        bit found;
        logic [31:0] ma;
        do_reset;
        fill_line(A, 0, found, ma);
        tick;
        tick;
        imem_addr  = D;
        imem_rmask = 4'h1;
        tick;
        checks++;
        if (imem_resp !== 1'b0) begin
            errors++; $display("FAIL redir_miss: got resp=%b expected 0", imem_resp);
        end
        wait_mem_read(found, ma);
        checks++;
        if (!found || ma !== D) begin
            errors++; $display("FAIL redir_mem_read: got found=%b addr=%h expected 1/%h", found, ma, D);
        end
        supply_beats(D, 0, 1, A);
        checks++;
        if (imem_resp !== 1'b0) begin
            errors++; $display("FAIL redir_fill_resp: got %b expected 0", imem_resp);
        end
        tick;
        checks++;
        if (imem_resp !== 1'b0) begin
            errors++; $display("FAIL redir_resample_resp: got %b expected 0", imem_resp);
        end
        tick;
        checks++;
        if (imem_resp !== 1'b1 || imem_rdata !== word_of(A)) begin
            errors++; $display("FAIL redir_resp: got resp=%b data=%h expected 1/%h",
                               imem_resp, imem_rdata, word_of(A));
        end
        imem_addr = D;
        tick;
        checks++;
        if (imem_resp !== 1'b1 || imem_rdata !== word_of(D) || mem_read !== 1'b0) begin
            errors++; $display("FAIL redir_d_hit: got resp=%b data=%h read=%b expected 1/%h/0",
                               imem_resp, imem_rdata, mem_read, word_of(D));
        end
        imem_rmask = 4'h0;
    endtask

    task automatic test_reset_mid_refill;
        bit found;
        logic [31:0] ma;
        do_reset;
        imem_addr  = A;
        imem_rmask = 4'hF;
        tick;
        wait_mem_read(found, ma);
        checks++;
        if (!found) begin
            errors++; $display("FAIL rst_mid_mem_read: got found=%b expected 1", found);
        end
        tick;
        mem_rvalid = 1'b1;
        mem_rdata  = beat_of(A, 0);
        tick;
        mem_rdata  = beat_of(A, 1);
        tick;
        mem_rvalid = 1'b0;
        rst        = 1'b1;
        imem_rmask = 4'h0;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = beat_of(A, i + 2);
            tick;
            checks++;
            if (imem_resp !== 1'b0 || mem_read !== 1'b0) begin
                errors++; $display("FAIL rst_stray_%0d: got resp=%b read=%b expected 0/0",
                                   i, imem_resp, mem_read);
            end
        end
        mem_rvalid = 1'b0;
        imem_addr  = A;
        imem_rmask = 4'hF;
        tick;
        checks++;
        if (imem_resp !== 1'b0) begin
            errors++; $display("FAIL rst_after_miss: got resp=%b expected 0", imem_resp);
        end
        tick;
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== A) begin
            errors++; $display("FAIL rst_after_refetch: got read=%b addr=%h expected 1/%h",
                               mem_read, mem_addr, A);
        end
        imem_rmask = 4'h0;
    endtask

    task automatic test_idle_port;
        bit found;
        logic [31:0] ma;
        do_reset;
        fill_line(A, 0, found, ma);
        tick;
        tick;
        fill_line(B, 0, found, ma);
        tick;
        tick;
        // Set 0 LRU now points at way 0 (A); idle cycles on A must not change it.
        imem_addr  = A;
        imem_rmask = 4'h0;
        for (int i = 0; i < 10; i++) begin
            tick;
            checks++;
            if (imem_resp !== 1'b0 || mem_read !== 1'b0) begin
                errors++; $display("FAIL idle_%0d: got resp=%b read=%b expected 0/0",
                                   i, imem_resp, mem_read);
            end
        end
        fill_line(C, 0, found, ma);
        tick;
        tick;
        imem_addr = B;
        tick;
        checks++;
        if (imem_resp !== 1'b1 || imem_rdata !== word_of(B)) begin
            errors++; $display("FAIL idle_b_kept: got resp=%b data=%h expected 1/%h",
                               imem_resp, imem_rdata, word_of(B));
        end
        imem_addr = A;
        tick;
        tick;
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== A) begin
            errors++; $display("FAIL idle_a_evicted: got read=%b addr=%h expected 1/%h",
                               mem_read, mem_addr, A);
        end
        imem_rmask = 4'h0;
    endtask

    initial begin
        test_reset;
        test_cold_miss;
        test_streaming;
        test_conflict_lru;
        test_redirect;
        test_reset_mid_refill;
        test_idle_port;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
